// File: rtl/ad7124_pkg.sv
// Shared definitions for the AD7124 scan engine: scanner states, the SPI read
// command and the layout of the result word written to the BRAM port.
package ad7124_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StWaitRdy,
        StShift,
        StHold,
        StStore,
        StNext,
        StDone
    } state_e;

    // Communications-register byte: read, data register 0x02.
    localparam logic [7:0]  CMD_READ_DATA = 8'h42;
    localparam int unsigned FRAME_BITS    = 32;
    localparam int unsigned TIMEOUT_BIT   = 31;
    localparam int unsigned DATA_WIDTH    = 24;

    // Result slot of a (board, chip select) pair; also the spi_csn bit index.
    function automatic int unsigned result_addr(input int unsigned board,
                                                input int unsigned cs,
                                                input int unsigned num_cs);
        return board * num_cs + cs;
    endfunction

endpackage

// File: rtl/ad7124_scan_engine_if.sv
// Result write port of the scan engine (BRAM-style, write only).
//   mem_we     : one-cycle write strobe
//   mem_addr   : board * NUM_OF_CS + cs
//   mem_wrdata : {timeout, 7'b0, data[23:0]}
// master = scan engine, slave = result memory.
interface ad7124_scan_engine_if #(
    parameter int unsigned MEM_ADDR_WIDTH = 8
);
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_wrdata;

    modport master (output mem_we, output mem_addr, output mem_wrdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wrdata);
endinterface

// File: rtl/ad7124_spi_phy.sv
// Shared SPI bit engine for all boards (mode 3, MSB first, 32-bit frame).
//   start  : begin a frame (ignored while a frame is running)
//   done   : high in the last cycle of the frame; SCLK is left high
//   sample : per-board strobe, high in the cycle SCLK rises on data bits 8..31
//   sclk   : registered SCLK, idle high; low CLK_DIV cycles then high CLK_DIV
//   sdi    : registered DIN, changes with SCLK falling edges
module ad7124_spi_phy
    import ad7124_pkg::*;
#(
    parameter int unsigned NUM_OF_BOARD = 6,
    parameter int unsigned CLK_DIV      = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    output logic                    done,
    output logic [NUM_OF_BOARD-1:0] sample,
    output logic                    sclk,
    output logic                    sdi
);
    localparam logic [31:0] FRAME = {CMD_READ_DATA, 24'h000000};
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic             busy_q, busy_d;
    logic             high_q, high_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             sdi_q, sdi_d;
    logic             half_end;

    assign half_end = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        busy_d = busy_q;
        high_d = high_q;
        div_d  = div_q;
        bit_d  = bit_q;
        sclk_d = sclk_q;
        sdi_d  = sdi_q;
        done   = 1'b0;
        if (!busy_q) begin
            if (start) begin
                busy_d = 1'b1;
                high_d = 1'b0;
                div_d  = '0;
                bit_d  = '0;
                sclk_d = 1'b0;
                sdi_d  = FRAME[31];
            end
        end else if (!half_end) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = '0;
            if (!high_q) begin
                high_d = 1'b1;
                sclk_d = 1'b1;
            end else if (bit_q == 5'd31) begin
                // Frame complete: SCLK stays high for the scanner's hold phase.
                busy_d = 1'b0;
                high_d = 1'b0;
                sdi_d  = 1'b0;
                done   = 1'b1;
            end else begin
                high_d = 1'b0;
                sclk_d = 1'b0;
                bit_d  = bit_q + 5'd1;
                sdi_d  = FRAME[5'd30 - bit_q];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            busy_q <= 1'b0;
            high_q <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b1;
            sdi_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            high_q <= high_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
            sdi_q  <= sdi_d;
        end
    end

    // First high cycle of a data bit; command-byte bits are not captured.
    assign sample = {NUM_OF_BOARD{busy_q && high_q && (div_q == '0) && (bit_q >= 5'd8)}};
    assign sclk   = sclk_q;
    assign sdi    = sdi_q;

endmodule

// File: rtl/ad7124_scan_engine.sv
// Autonomous multi-board AD7124 scanner. Walks the enabled chip selects, waits
// for RDY on every board, reads the 24-bit data register over per-board SPI
// buses in lockstep and writes one flagged result word per board.
//   aclk/areset      : clock, async active-high reset
//   ctrl_*           : start pulse, continuous mode, cs mask, busy status
//   irq, scan_count  : end-of-scan pulse and wrapping completed-scan counter
//   spi_*            : SCLK/CSN/DIN per board, DOUT/RDY from each board
//   mem              : result write port
module ad7124_scan_engine
    import ad7124_pkg::*;
#(
    parameter int unsigned NUM_OF_BOARD   = 6,
    parameter int unsigned NUM_OF_CS      = 8,
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned RDY_TIMEOUT    = 65535,
    parameter int unsigned MEM_ADDR_WIDTH = 8
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              ctrl_start,
    input  logic                              ctrl_continuous,
    input  logic [NUM_OF_CS-1:0]              ctrl_cs_mask,
    output logic                              ctrl_busy,
    output logic                              irq,
    output logic [15:0]                       scan_count,
    output logic [NUM_OF_BOARD-1:0]           spi_sclk,
    output logic [NUM_OF_BOARD*NUM_OF_CS-1:0] spi_csn,
    output logic [NUM_OF_BOARD-1:0]           spi_sdi,
    input  logic [NUM_OF_BOARD-1:0]           spi_sdo,
    ad7124_scan_engine_if.master              mem
);
    localparam int unsigned CS_W   = (NUM_OF_CS > 1) ? $clog2(NUM_OF_CS) : 1;
    localparam int unsigned BASE_W = $clog2(NUM_OF_CS + 1);
    localparam int unsigned BRD_W  = (NUM_OF_BOARD > 1) ? $clog2(NUM_OF_BOARD) : 1;

    state_e                      state_q, state_d;
    logic [CS_W-1:0]             cs_q, cs_d;
    logic [BASE_W-1:0]           base_q, base_d;  // first index NEXT may pick
    logic [31:0]                 cnt_q, cnt_d;
    logic [BRD_W-1:0]            brd_q, brd_d;
    logic [NUM_OF_BOARD-1:0]     sdo_meta_q, sdo_sync_q;
    logic [NUM_OF_BOARD-1:0]     tout_q, tout_d;
    logic [DATA_WIDTH-1:0]       data_q [NUM_OF_BOARD];
    logic [DATA_WIDTH-1:0]       data_d [NUM_OF_BOARD];
    logic [NUM_OF_BOARD*NUM_OF_CS-1:0] csn_q, csn_d;
    logic                        busy_q, busy_d, irq_q, irq_d, we_q, we_d;
    logic [15:0]                 count_q, count_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]                 wrdata_q, wrdata_d;

    logic                        nxt_found;
    logic [CS_W-1:0]             nxt_cs;
    logic                        phy_start, phy_done, phy_sclk, phy_sdi;
    logic [NUM_OF_BOARD-1:0]     phy_sample;

    ad7124_spi_phy #(
        .NUM_OF_BOARD(NUM_OF_BOARD),
        .CLK_DIV     (CLK_DIV)
    ) u_phy (
        .aclk  (aclk),
        .areset(areset),
        .start (phy_start),
        .done  (phy_done),
        .sample(phy_sample),
        .sclk  (phy_sclk),
        .sdi   (phy_sdi)
    );

    // Lowest enabled chip select at or above base_q; descending loop so the
    // lowest match wins.
    always_comb begin
        nxt_found = 1'b0;
        nxt_cs    = '0;
        for (int i = NUM_OF_CS - 1; i >= 0; i--) begin
            if (ctrl_cs_mask[i] && (i >= int'(base_q))) begin
                nxt_found = 1'b1;
                nxt_cs    = CS_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        brd_d     = brd_q;
        tout_d    = tout_q;
        data_d    = data_q;
        count_d   = count_q;
        phy_start = 1'b0;
        for (int b = 0; b < NUM_OF_BOARD; b++) begin
            if (phy_sample[b]) data_d[b] = {data_q[b][DATA_WIDTH-2:0], spi_sdo[b]};
        end
        unique case (state_q)
            StIdle: begin
                if (ctrl_start) begin
                    base_d  = '0;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (nxt_found) begin
                    cs_d    = nxt_cs;
                    base_d  = BASE_W'(nxt_cs) + BASE_W'(1);
                    cnt_d   = '0;
                    state_d = StSelect;
                end else begin
                    count_d = count_q + 16'd1;
                    state_d = StDone;
                end
            end
            StSelect: begin
                if (cnt_q == CLK_DIV - 1) begin
                    cnt_d   = '0;
                    state_d = StWaitRdy;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitRdy: begin
                if ((sdo_sync_q == '0) || (cnt_q == RDY_TIMEOUT - 1)) begin
                    tout_d    = sdo_sync_q;  // boards still busy are flagged
                    phy_start = 1'b1;
                    state_d   = StShift;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StShift: begin
                if (phy_done) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == CLK_DIV - 1) begin
                    brd_d   = '0;
                    state_d = StStore;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StStore: begin
                if (brd_q == BRD_W'(NUM_OF_BOARD - 1)) state_d = StNext;
                else                                   brd_d   = brd_q + BRD_W'(1);
            end
            StDone: begin
                base_d  = '0;
                state_d = ctrl_continuous ? StNext : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs derived from the next state.
    always_comb begin
        busy_d   = (state_d != StIdle);
        irq_d    = (state_d == StDone);
        we_d     = (state_d == StStore);
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        csn_d    = '1;
        if (state_d inside {StSelect, StWaitRdy, StShift, StHold}) begin
            csn_d = ~{NUM_OF_BOARD{NUM_OF_CS'(1) << cs_d}};
        end
        if (we_d) begin
            addr_d   = MEM_ADDR_WIDTH'(result_addr(32'(brd_d), 32'(cs_q), NUM_OF_CS));
            wrdata_d = '0;
            wrdata_d[TIMEOUT_BIT]      = tout_q[brd_d];
            wrdata_d[DATA_WIDTH-1:0]   = data_q[brd_d];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= StIdle;
            cs_q       <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            brd_q      <= '0;
            sdo_meta_q <= '1;
            sdo_sync_q <= '1;
            tout_q     <= '0;
            data_q     <= '{default: '0};
            csn_q      <= '1;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            we_q       <= 1'b0;
            count_q    <= '0;
            addr_q     <= '0;
            wrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            brd_q      <= brd_d;
            sdo_meta_q <= spi_sdo;
            sdo_sync_q <= sdo_meta_q;
            tout_q     <= tout_d;
            data_q     <= data_d;
            csn_q      <= csn_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
            we_q       <= we_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
        end
    end

    assign ctrl_busy      = busy_q;
    assign irq            = irq_q;
    assign scan_count     = count_q;
    assign spi_csn        = csn_q;
    assign spi_sclk       = {NUM_OF_BOARD{phy_sclk}};
    assign spi_sdi        = {NUM_OF_BOARD{phy_sdi}};
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wrdata = wrdata_q;

endmodule

// File: tb/tb_ad7124_scan_engine.sv
// Scoreboard bench: each scan request pushes the expected result words; a
// monitor pops and compares on every mem_we. Behavioural ADC models answer on
// each board's SPI bus.
module tb_ad7124_scan_engine;
    localparam int unsigned NB          = 6;
    localparam int unsigned NCS         = 8;
    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned RDY_TIMEOUT = 100;
    localparam int unsigned AW          = 8;
    localparam int unsigned RDY_DELAY   = 10;
    localparam int          BUDGET      = 20000;
    localparam logic [NB*NCS-1:0] CSN_IDLE  = '1;
    localparam logic [NB-1:0]     SCLK_IDLE = '1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              ctrl_start = 1'b0;
    logic              ctrl_continuous = 1'b0;
    logic [NCS-1:0]    ctrl_cs_mask = '0;
    logic              ctrl_busy, irq;
    logic [15:0]       scan_count;
    logic [NB-1:0]     spi_sclk, spi_sdi;
    logic [NB*NCS-1:0] spi_csn;
    logic [NB-1:0]     spi_sdo = '1;

    ad7124_scan_engine_if #(.MEM_ADDR_WIDTH(AW)) mem_bus ();

    ad7124_scan_engine #(
        .NUM_OF_BOARD  (NB),
        .NUM_OF_CS     (NCS),
        .CLK_DIV       (CLK_DIV),
        .RDY_TIMEOUT   (RDY_TIMEOUT),
        .MEM_ADDR_WIDTH(AW)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .ctrl_start     (ctrl_start),
        .ctrl_continuous(ctrl_continuous),
        .ctrl_cs_mask   (ctrl_cs_mask),
        .ctrl_busy      (ctrl_busy),
        .irq            (irq),
        .scan_count     (scan_count),
        .spi_sclk       (spi_sclk),
        .spi_csn        (spi_csn),
        .spi_sdi        (spi_sdi),
        .spi_sdo        (spi_sdo),
        .mem            (mem_bus)
    );

    always #5 aclk = ~aclk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [23:0]   adc_val [NB][NCS];
    logic [NB-1:0] stuck = '0;
    int   irq_cnt = 0, we_cnt = 0, frames_started = 0, last_frame_len = 0;
    int   rst_events = 0;
    int   exp_scans = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_scan(input logic [NCS-1:0] m);
        for (int c = 0; c < NCS; c++) begin
            if (m[c]) begin
                for (int b = 0; b < NB; b++) begin
                    exp_t e;
                    e.addr = AW'(b * NCS + c);
                    // A stuck board never releases DOUT, so it reads back all ones.
                    e.data = stuck[b] ? 32'h80FF_FFFF : {8'h00, adc_val[b][c]};
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic randomize_adc();
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NCS; c++) adc_val[b][c] = 24'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge aclk);
        ctrl_start = 1'b1;
        @(negedge aclk);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (ctrl_busy && n < BUDGET) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (ctrl_busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, BUDGET);
        end
        @(negedge aclk);
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!irq && n < BUDGET);
        checks++;
        if (!irq) begin
            errors++;
            $display("FAIL %s: no irq within %0d cycles", name, BUDGET);
        end
    endtask

    // ADC model: RDY falls RDY_DELAY cycles after its CSN falls, then DOUT
    // changes after each SCLK falling edge: 8 filler bits, then the 24 data bits.
    initial begin
        int          low_cnt [NB];
        int          fall_cnt [NB];
        logic        prev_sclk [NB];
        int          sel;
        logic [31:0] word;
        for (int b = 0; b < NB; b++) begin
            low_cnt[b]   = 0;
            fall_cnt[b]  = 0;
            prev_sclk[b] = 1'b1;
        end
        forever begin
            @(negedge aclk);
            for (int b = 0; b < NB; b++) begin
                sel = -1;
                for (int c = 0; c < NCS; c++) if (!spi_csn[b*NCS+c]) sel = c;
                if (sel < 0) begin
                    low_cnt[b]  = 0;
                    fall_cnt[b] = 0;
                    spi_sdo[b]  = 1'b1;
                end else begin
                    low_cnt[b]++;
                    if (prev_sclk[b] && !spi_sclk[b]) fall_cnt[b]++;
                    if (stuck[b]) begin
                        spi_sdo[b] = 1'b1;
                    end else if (fall_cnt[b] == 0) begin
                        spi_sdo[b] = (low_cnt[b] < RDY_DELAY);
                    end else if (fall_cnt[b] <= 32) begin
                        word = {8'hA5, adc_val[b][sel]};
                        spi_sdo[b] = word[32-fall_cnt[b]];
                    end
                end
                prev_sclk[b] = spi_sclk[b];
            end
        end
    end

    // Result-write monitor / scoreboard.
    always @(negedge aclk) begin
        exp_t e;
        if (irq) irq_cnt++;
        if (!areset && mem_bus.mem_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_write: got addr %0d data 0x%08h, expected no write",
                         mem_bus.mem_addr, mem_bus.mem_wrdata);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", 64'(mem_bus.mem_addr), 64'(e.addr));
                check("mem_wrdata", 64'(mem_bus.mem_wrdata), 64'(e.data));
            end
        end
    end

    // Board-0 frame monitor: SDI captured on SCLK rising edges.
    initial begin
        logic        in_frame, fprev_sclk;
        int          frame_len, rises, lows, frame_rst;
        logic [31:0] frame_bits;
        in_frame   = 1'b0;
        fprev_sclk = 1'b1;
        frame_len  = 0;
        rises      = 0;
        lows       = 0;
        frame_rst  = 0;
        frame_bits = '0;
        forever begin
            @(negedge aclk);
            if (!(&spi_csn[NCS-1:0])) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    frames_started++;
                    frame_len  = 0;
                    rises      = 0;
                    lows       = 0;
                    frame_bits = '0;
                    frame_rst  = rst_events;
                end
                frame_len++;
                if (!spi_sclk[0]) lows++;
                if (!fprev_sclk && spi_sclk[0]) begin
                    rises++;
                    frame_bits = {frame_bits[30:0], spi_sdi[0]};
                end
            end else if (in_frame) begin
                in_frame       = 1'b0;
                last_frame_len = frame_len;
                if (frame_rst == rst_events) begin
                    check("sdi_frame", 64'(frame_bits), 64'h4200_0000);
                    check("sclk_rises", 64'(rises), 64'd32);
                    check("sclk_low_cycles", 64'(lows), 64'(32 * CLK_DIV));
                end
            end
            fprev_sclk = spi_sclk[0];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            irq0, we0, fr0, n;
        logic [NCS-1:0] m;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_csn", 64'(spi_csn), 64'(CSN_IDLE));
        check("rst_sclk", 64'(spi_sclk), 64'(SCLK_IDLE));
        check("rst_sdi", 64'(spi_sdi), 64'd0);
        check("rst_mem_we", 64'(mem_bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_bus.mem_addr), 64'd0);
        check("rst_mem_wrdata", 64'(mem_bus.mem_wrdata), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_busy", 64'(ctrl_busy), 64'd0);
        check("rst_scan_count", 64'(scan_count), 64'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Single chip select, fixed value on every board
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NCS; c++) adc_val[b][c] = 24'h123456;
        ctrl_cs_mask = 8'h01;
        push_scan(ctrl_cs_mask);
        irq0 = irq_cnt;
        pulse_start();
        check("busy_in_scan", 64'(ctrl_busy), 64'd1);
        wait_idle("scan_mask01");
        exp_scans++;
        check("irq_once", 64'(irq_cnt - irq0), 64'd1);
        check("scan_count_1", 64'(scan_count), 64'(exp_scans));
        check("queue_empty_1", 64'(exp_q.size()), 64'd0);

        // Board 3 never signals RDY: full timeout, flagged word
        randomize_adc();
        stuck = 6'b001000;
        ctrl_cs_mask = NCS'(1) << $urandom_range(0, NCS - 1);
        push_scan(ctrl_cs_mask);
        pulse_start();
        wait_idle("scan_timeout");
        exp_scans++;
        check("csn_low_len_timeout", 64'(last_frame_len),
              64'(CLK_DIV + RDY_TIMEOUT + 64 * CLK_DIV + CLK_DIV));
        check("queue_empty_2", 64'(exp_q.size()), 64'd0);
        stuck = '0;

        // Sparse mask; second start mid-scan must be ignored
        randomize_adc();
        ctrl_cs_mask = 8'hA5;
        push_scan(ctrl_cs_mask);
        pulse_start();
        repeat (50) @(negedge aclk);
        pulse_start();
        wait_idle("scan_maskA5");
        exp_scans++;
        check("scan_count_A5", 64'(scan_count), 64'(exp_scans));
        check("queue_empty_3", 64'(exp_q.size()), 64'd0);
        check("sclk_idle_high", 64'(spi_sclk), 64'(SCLK_IDLE));
        check("csn_idle_high", 64'(spi_csn), 64'(CSN_IDLE));

        // Random masks
        for (int t = 0; t < 2; t++) begin
            randomize_adc();
            ctrl_cs_mask = NCS'($urandom_range(1, 255));
            push_scan(ctrl_cs_mask);
            pulse_start();
            wait_idle("scan_random");
            exp_scans++;
            check("queue_empty_rand", 64'(exp_q.size()), 64'd0);
        end

        // Continuous mode for three scans
        randomize_adc();
        ctrl_cs_mask = NCS'($urandom_range(1, 255));
        for (int s = 0; s < 3; s++) push_scan(ctrl_cs_mask);
        irq0 = irq_cnt;
        ctrl_continuous = 1'b1;
        pulse_start();
        wait_irq("cont_irq1");
        repeat (20) @(negedge aclk);
        pulse_start();
        wait_irq("cont_irq2");
        repeat (5) @(negedge aclk);
        ctrl_continuous = 1'b0;
        wait_irq("cont_irq3");
        check("busy_at_done", 64'(ctrl_busy), 64'd1);
        @(negedge aclk);
        check("busy_after_done", 64'(ctrl_busy), 64'd0);
        exp_scans += 3;
        repeat (3) @(negedge aclk);
        check("cont_irq_count", 64'(irq_cnt - irq0), 64'd3);
        check("cont_scan_count", 64'(scan_count), 64'(exp_scans));
        check("queue_empty_cont", 64'(exp_q.size()), 64'd0);

        // Empty mask: no bus activity, irq promptly
        ctrl_cs_mask = '0;
        we0 = we_cnt;
        fr0 = frames_started;
        @(negedge aclk);
        ctrl_start = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
            ctrl_start = 1'b0;
        end while (!irq && n < 10);
        check("empty_irq_latency_ok", 64'(irq && n <= 3), 64'd1);
        wait_idle("scan_empty");
        exp_scans++;
        check("empty_no_we", 64'(we_cnt - we0), 64'd0);
        check("empty_no_csn", 64'(frames_started - fr0), 64'd0);
        check("empty_scan_count", 64'(scan_count), 64'(exp_scans));

        // Asynchronous reset in the middle of SHIFT
        randomize_adc();
        ctrl_cs_mask = 8'hFF;
        pulse_start();
        n = 0;
        while (spi_sclk[0] && n < BUDGET) begin
            @(negedge aclk);
            n++;
        end
        check("reached_shift", 64'(spi_sclk[0]), 64'd0);
        @(posedge aclk);
        #2;
        rst_events++;
        areset = 1'b1;
        #1;
        check("midrst_csn", 64'(spi_csn), 64'(CSN_IDLE));
        check("midrst_sclk", 64'(spi_sclk), 64'(SCLK_IDLE));
        check("midrst_busy", 64'(ctrl_busy), 64'd0);
        check("midrst_mem_we", 64'(mem_bus.mem_we), 64'd0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        exp_scans = 0;
        exp_q.delete();
        check("midrst_scan_count", 64'(scan_count), 64'd0);
        @(negedge aclk);

        randomize_adc();
        ctrl_cs_mask = NCS'($urandom_range(1, 255));
        push_scan(ctrl_cs_mask);
        pulse_start();
        wait_idle("scan_after_reset");
        exp_scans++;
        check("post_rst_scan_count", 64'(scan_count), 64'(exp_scans));
        check("queue_empty_final", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
